clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Runtime-programmable clock divider; successor to the fixed divide-by-3 divider.
//  Produces a registered divided-clock level (clkout) with programmable period and
//  high time, plus a one-cycle tick per period for use as a clock enable.
//  Sits beside the top-level clock input and paces slower datapath/test logic.
// PARAMETERS
//  DIV_W        8   width of divisor/high-time fields (max divisor 2**DIV_W-1)
//  DEFAULT_DIV  3   active divisor after reset (must be >= 2)
//  DEFAULT_HI   1   active high time after reset (1..DEFAULT_DIV-1)
//  PCNT_W       16  width of period counter (optional feature only)
// PORTS
//  clkin       in   1       system clock; all logic on posedge
//  reset       in   1       synchronous, active-high reset
//  en          in   1       run divider when high; idle when low
//  cfg_valid   in   1       new config offered
//  cfg_ready   out  1       config can be accepted (= no config pending)
//  cfg_div     in   DIV_W   requested period in clkin cycles
//  cfg_hi      in   DIV_W   requested clkout high cycles per period
//  cfg_err     out  1       1-cycle pulse: offered config rejected
//  clkout      out  1       divided clock level (registered)
//  tick        out  1       1-cycle pulse in last cycle of each period
//  cur_div     out  DIV_W   active divisor
//  period_cnt  out  PCNT_W  completed periods (CLKDIV_PERIOD_CNT_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, clkout=0, tick=0, cfg_err=0, cfg_ready=1,
//   div_a=DEFAULT_DIV, hi_a=DEFAULT_HI, pending cleared, period_cnt=0.
//  Handshake: transfer when cfg_valid && cfg_ready. cfg_div<2 -> rejected:
//   cfg_err=1 next cycle, no state change. cfg_hi clamped: 0 -> 1; >=cfg_div -> cfg_div-1.
//  Accepted config in IDLE: becomes active next cycle; cfg_ready stays 1.
//  Accepted config in RUN: held pending (cfg_ready=0) until next period boundary
//   (cycle with cnt==div_a-1); then div_a/hi_a load, cnt->0, cfg_ready->1.
//   Accept in the boundary cycle itself is applied at that same boundary.
//  FSM IDLE: cnt=0, clkout=0, tick=0. en=1 -> RUN with cnt<=0, clkout<=1.
//  FSM RUN: cnt_nxt = (cnt==div_a-1) ? 0 : cnt+1; clkout <= (cnt_nxt < hi_a);
//   tick <= (cnt_nxt == div_a-1). en=0 -> IDLE next cycle (clkout<=0,
//   tick<=0, cnt<=0); a pending config is applied on entering IDLE.
//  Period = div_a cycles exactly; clkout high for first hi_a cycles of each period.
//  Latency: en rise -> clkout=1 one cycle later; tick first seen div_a cycles later.
//  Reset mid-operation overrides everything; pending config discarded.
// CONFIGURATION
//  CLKDIV_PERIOD_CNT_EN defined: period_cnt port exists, increments (wraps mod
//   2**PCNT_W) on each tick, holds in IDLE, cleared by reset only.
//  Not defined: period_cnt port and counter absent; all else identical.
// STRUCTURE
//  Package clk_div_pkg: state enum {IDLE, RUN}; DIV_MIN=2 constant;
//   cfg struct {div, hi} typed with DIV_W.
//  Sub-module clk_div_cfg: validation, clamp, pending register, cfg_ready/cfg_err.
//  Top: FSM, counter, clkout/tick flops, optional period counter.
// TESTING
//  1 reset, en=1, defaults -> clkout 1,0,0 repeating; tick in every 3rd cycle.
//  2 IDLE load div=5 hi=2, en=1 -> clkout 1,1,0,0,0 repeating; cur_div=5.
//  3 RUN div=3, load div=4 hi=2 at cnt=0 -> cfg_ready=0 two cycles, new
//    pattern 1,1,0,0 starts exactly at next boundary; no short/long period.
//  4 offer div=1 or div=0 -> cfg_err pulse 1 cycle, cur_div unchanged.
//  5 load div=4 hi=9 -> clamped hi=3: 1,1,1,0; hi=0 -> clamped hi=1.
//  6 en drop mid-period -> clkout=0 next cycle; reset during pending -> defaults,
//    cfg_ready=1; with CLKDIV_PERIOD_CNT_EN, 10 periods -> period_cnt=10.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and constants for the programmable clock divider.
//   state_t   : divider FSM states (IDLE, RUN)
//   DIV_MIN   : smallest divisor the divider will accept
//   cfg_t     : divisor / high-time pair, CFG_DIV_W bits per field
//   clamp_cfg : forces high time into 1..div-1
package clk_div_pkg;

  localparam int unsigned CFG_DIV_W = 8;
  localparam logic [CFG_DIV_W-1:0] DIV_MIN = CFG_DIV_W'(2);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    logic [CFG_DIV_W-1:0] hi;
  } cfg_t;

  function automatic cfg_t clamp_cfg(input logic [CFG_DIV_W-1:0] div,
                                     input logic [CFG_DIV_W-1:0] hi);
    cfg_t c;
    c.div = div;
    if (hi == '0)
      c.hi = CFG_DIV_W'(1);
    else if (hi >= div)
      c.hi = div - CFG_DIV_W'(1);
    else
      c.hi = hi;
    return c;
  endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// clk_div_cfg: configuration front end of the programmable clock divider.
// Validates offered configs, clamps the high time, holds a config offered
// while running until the next period boundary, and owns the active config.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   i_cfg_valid         : config offered
//   i_cfg_div, i_cfg_hi : requested divisor / high time
//   i_run               : divider FSM is in RUN
//   i_apply             : RUN cycle in which a new config may take effect
//                         (period boundary or leaving RUN)
//   o_cfg_ready         : no config pending
//   o_cfg_err           : one-cycle pulse after a rejected offer
//   o_div, o_hi         : active divisor / high time
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 3,
  parameter int unsigned DEFAULT_HI  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_cfg_valid,
  input  logic [CFG_DIV_W-1:0] i_cfg_div,
  input  logic [CFG_DIV_W-1:0] i_cfg_hi,
  input  logic                 i_run,
  input  logic                 i_apply,
  output logic                 o_cfg_ready,
  output logic                 o_cfg_err,
  output logic [CFG_DIV_W-1:0] o_div,
  output logic [CFG_DIV_W-1:0] o_hi
);

  cfg_t r_act;
  cfg_t r_pend;
  logic r_pend_vld;
  logic r_err;

  logic w_accept;
  logic w_bad;
  cfg_t w_req;

  assign w_accept = i_cfg_valid && !r_pend_vld;
  assign w_bad    = (i_cfg_div < DIV_MIN);
  assign w_req    = clamp_cfg(i_cfg_div, i_cfg_hi);

  // A fresh accept and a pending config are mutually exclusive because
  // cfg_ready is low whenever something is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_act      <= '{div: CFG_DIV_W'(DEFAULT_DIV), hi: CFG_DIV_W'(DEFAULT_HI)};
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_accept && w_bad;
      if (w_accept && !w_bad) begin
        // Idle, or offered in the very cycle it may take effect: load now.
        if (!i_run || i_apply) begin
          r_act <= w_req;
        end else begin
          r_pend     <= w_req;
          r_pend_vld <= 1'b1;
        end
      end else if (r_pend_vld && i_apply) begin
        r_act      <= r_pend;
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign o_cfg_ready = !r_pend_vld;
  assign o_cfg_err   = r_err;
  assign o_div       = r_act.div;
  assign o_hi        = r_act.hi;

endmodule

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider.
// Produces a registered divided clock level (clkout), high for the first
// hi cycles of every div-cycle period, and a one-cycle tick in the last
// cycle of each period. New configs offered while running take effect at
// the next period boundary so no short or long period is ever produced.
// Optional feature macro: CLKDIV_PERIOD_CNT_EN adds the period_cnt output.
// DIV_W must equal clk_div_pkg::CFG_DIV_W (the config struct width).
// Ports:
//   clkin, reset        : clock, synchronous active-high reset
//   en                  : run when high, idle when low
//   cfg_valid/cfg_ready : config handshake
//   cfg_div, cfg_hi     : requested period / high time (clkin cycles)
//   cfg_err             : one-cycle pulse, offered config rejected (div < 2)
//   clkout              : divided clock level
//   tick                : pulse in last cycle of each period
//   cur_div             : active divisor
//   period_cnt          : completed periods (CLKDIV_PERIOD_CNT_EN only)
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = CFG_DIV_W,
  parameter int unsigned DEFAULT_DIV = 3,
  parameter int unsigned DEFAULT_HI  = 1
`ifdef CLKDIV_PERIOD_CNT_EN
  ,
  parameter int unsigned PCNT_W      = 16
`endif
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_hi,
  output logic             cfg_err,
  output logic             clkout,
  output logic             tick,
  output logic [DIV_W-1:0] cur_div
`ifdef CLKDIV_PERIOD_CNT_EN
  ,
  output logic [PCNT_W-1:0] period_cnt
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             r_clkout;
  logic             w_clkout_nxt;
  logic             r_tick;
  logic             w_tick_nxt;

  logic [DIV_W-1:0] w_div_a;
  logic [DIV_W-1:0] w_hi_a;
  logic             w_last;
  logic             w_apply;

  assign w_last  = (r_cnt == w_div_a - DIV_W'(1));
  // Configs change only on a period boundary or when dropping back to IDLE.
  assign w_apply = (r_state == RUN) && (w_last || !en);

  clk_div_cfg #(
    .DEFAULT_DIV (DEFAULT_DIV),
    .DEFAULT_HI  (DEFAULT_HI)
  ) u_cfg (
    .clk         (clkin),
    .reset       (reset),
    .i_cfg_valid (cfg_valid),
    .i_cfg_div   (cfg_div),
    .i_cfg_hi    (cfg_hi),
    .i_run       (r_state == RUN),
    .i_apply     (w_apply),
    .o_cfg_ready (cfg_ready),
    .o_cfg_err   (cfg_err),
    .o_div       (w_div_a),
    .o_hi        (w_hi_a)
  );

  // At a boundary cnt_nxt is 0; hi >= 1 and div >= 2 for any config, so
  // comparing against the outgoing config gives the same result as the
  // incoming one.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = '0;
    w_clkout_nxt = 1'b0;
    w_tick_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (en) begin
          w_state_nxt  = RUN;
          w_clkout_nxt = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt    = w_last ? '0 : r_cnt + DIV_W'(1);
          w_clkout_nxt = (w_cnt_nxt < w_hi_a);
          w_tick_nxt   = (w_cnt_nxt == w_div_a - DIV_W'(1));
        end
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_clkout <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_clkout <= w_clkout_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

`ifdef CLKDIV_PERIOD_CNT_EN
  logic [PCNT_W-1:0] r_pcnt;

  // tick is never high in IDLE, so the count holds there naturally.
  always_ff @(posedge clkin) begin
    if (reset)
      r_pcnt <= '0;
    else if (r_tick)
      r_pcnt <= r_pcnt + PCNT_W'(1);
  end

  assign period_cnt = r_pcnt;
`endif

  assign clkout  = r_clkout;
  assign tick    = r_tick;
  assign cur_div = w_div_a;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed self-checking bench for clk_div_prog.
// Inputs are driven and outputs sampled 1 ns after each rising clkin edge.
module tb_clk_div_prog;

  logic       clkin = 1'b0;
  logic       reset;
  logic       en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_div;
  logic [7:0] cfg_hi;
  logic       cfg_err;
  logic       clkout;
  logic       tick;
  logic [7:0] cur_div;
`ifdef CLKDIV_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clkin = ~clkin;

  clk_div_prog #(
    .DIV_W       (8),
    .DEFAULT_DIV (3),
    .DEFAULT_HI  (1)
  ) dut (
    .clkin      (clkin),
    .reset      (reset),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_div    (cfg_div),
    .cfg_hi     (cfg_hi),
    .cfg_err    (cfg_err),
    .clkout     (clkout),
    .tick       (tick),
    .cur_div    (cur_div)
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  // One-cycle config offer; returns after the accepting edge.
  task automatic offer(input logic [7:0] d, input logic [7:0] h);
    cfg_div   = d;
    cfg_hi    = h;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  // Patterns are MSB-first: bit n-1 is the first sampled cycle.
  task automatic run_pattern(input string tag, input int unsigned n,
                             input logic [31:0] clk_pat, input logic [31:0] tick_pat);
    for (int unsigned i = 0; i < n; i++) begin
      step();
      check({tag, "_clk"},  {31'd0, clkout}, {31'd0, clk_pat[n-1-i]});
      check({tag, "_tick"}, {31'd0, tick},   {31'd0, tick_pat[n-1-i]});
    end
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_hi    = '0;
    step();
    step();
    check("rst_clkout", {31'd0, clkout},    32'd0);
    check("rst_tick",   {31'd0, tick},      32'd0);
    check("rst_ready",  {31'd0, cfg_ready}, 32'd1);
    check("rst_err",    {31'd0, cfg_err},   32'd0);
    check("rst_div",    {24'd0, cur_div},   32'd3);
    reset = 1'b0;
    step();

    // 1: defaults, divide by 3, high 1
    en = 1'b1;
    run_pattern("t1", 9, 32'b100100100, 32'b001001001);

    // 2: load div=5 hi=2 while idle
    en = 1'b0;
    step();
    check("t2_idle_clk", {31'd0, clkout}, 32'd0);
    check("t2_idle_tick", {31'd0, tick}, 32'd0);
    offer(8'd5, 8'd2);
    check("t2_div",   {24'd0, cur_div},   32'd5);
    check("t2_ready", {31'd0, cfg_ready}, 32'd1);
    en = 1'b1;
    run_pattern("t2", 10, 32'b1100011000, 32'b0000100001);

    // 3: change 3 -> 4/2 while running, offered at cnt=0
    en = 1'b0;
    step();
    offer(8'd3, 8'd1);
    check("t3_div3", {24'd0, cur_div}, 32'd3);
    en = 1'b1;
    step();
    check("t3_c0_clk",   {31'd0, clkout},    32'd1);
    check("t3_c0_ready", {31'd0, cfg_ready}, 32'd1);
    offer(8'd4, 8'd2);
    check("t3_c1_ready", {31'd0, cfg_ready}, 32'd0);
    check("t3_c1_clk",   {31'd0, clkout},    32'd0);
    check("t3_c1_div",   {24'd0, cur_div},   32'd3);
    step();
    check("t3_c2_ready", {31'd0, cfg_ready}, 32'd0);
    check("t3_c2_clk",   {31'd0, clkout},    32'd0);
    check("t3_c2_tick",  {31'd0, tick},      32'd1);
    run_pattern("t3", 8, 32'b11001100, 32'b00010001);
    check("t3_div4",  {24'd0, cur_div},   32'd4);
    check("t3_ready", {31'd0, cfg_ready}, 32'd1);

    // 4: rejected divisors while running
    offer(8'd1, 8'd0);
    check("t4_err1",   {31'd0, cfg_err}, 32'd1);
    check("t4_div1",   {24'd0, cur_div}, 32'd4);
    step();
    check("t4_err1_end", {31'd0, cfg_err}, 32'd0);
    offer(8'd0, 8'd5);
    check("t4_err0",   {31'd0, cfg_err}, 32'd1);
    check("t4_div0",   {24'd0, cur_div}, 32'd4);
    step();
    check("t4_err0_end", {31'd0, cfg_err},   32'd0);
    check("t4_ready",    {31'd0, cfg_ready}, 32'd1);
    check("t4_div_keep", {24'd0, cur_div},   32'd4);

    // 5: high-time clamping
    en = 1'b0;
    step();
    offer(8'd4, 8'd9);
    check("t5_div", {24'd0, cur_div}, 32'd4);
    en = 1'b1;
    run_pattern("t5a", 8, 32'b11101110, 32'b00010001);
    en = 1'b0;
    step();
    offer(8'd4, 8'd0);
    en = 1'b1;
    run_pattern("t5b", 8, 32'b10001000, 32'b00010001);

    // 6: en drop mid-period
    step();
    check("t6_run_clk", {31'd0, clkout}, 32'd1);
    en = 1'b0;
    step();
    check("t6_drop_clk",  {31'd0, clkout}, 32'd0);
    check("t6_drop_tick", {31'd0, tick},   32'd0);
    step();
    check("t6_idle_clk", {31'd0, clkout}, 32'd0);

    // 6: reset while a config is pending
    en = 1'b1;
    step();
    offer(8'd6, 8'd3);
    check("t6_pend_ready", {31'd0, cfg_ready}, 32'd0);
    check("t6_pend_div",   {24'd0, cur_div},   32'd4);
    reset = 1'b1;
    en    = 1'b0;
    step();
    check("t6_rst_ready", {31'd0, cfg_ready}, 32'd1);
    check("t6_rst_div",   {24'd0, cur_div},   32'd3);
    check("t6_rst_clk",   {31'd0, clkout},    32'd0);
    check("t6_rst_tick",  {31'd0, tick},      32'd0);
    check("t6_rst_err",   {31'd0, cfg_err},   32'd0);
    reset = 1'b0;
    step();
`ifdef CLKDIV_PERIOD_CNT_EN
    check("t6_pcnt0", {16'd0, period_cnt}, 32'd0);
`endif
    en = 1'b1;
    run_pattern("t6", 30, 32'b100100100100100100100100100100,
                          32'b001001001001001001001001001001);
    check("t6_div_default", {24'd0, cur_div}, 32'd3);
    en = 1'b0;
    step();
`ifdef CLKDIV_PERIOD_CNT_EN
    check("t6_pcnt10", {16'd0, period_cnt}, 32'd10);
    step();
    step();
    check("t6_pcnt_hold", {16'd0, period_cnt}, 32'd10);
`endif
    check("t6_end_clk", {31'd0, clkout}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
